sys_bridge: RTL and testbench
=============================

Name: sys_bridge

Overview:
- Parametrised CPU-to-peripheral system bridge for the P7 MIPS core.
- Decodes a word-aligned peripheral window into DEV_NUM device slots and drives one-hot device write enables.
- Returns registered read data with a one-cycle ready/error handshake, flags unmapped or misaligned accesses, and records the faulting address.
- Aggregates device interrupt lines into sticky, maskable pending bits that feed HWInt of CP0.

Parameters:
DEV_NUM, 2, number of device slots (1..6)
DEV_BASE, 32'h0000_7F00, byte address of slot 0
DEV_STRIDE, 32'h10, byte distance between consecutive slot bases
DEV_WORDS, 3, 32-bit registers per slot (slot i spans DEV_BASE+i*DEV_STRIDE .. +4*DEV_WORDS-4)
CTRL_BASE, 32'h0000_7F40, base of the bridge's own registers; must not overlap any slot

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
PrAddr  in  32  CPU byte address
PrWE  in  1  write request, single-cycle
PrRE  in  1  read request, single-cycle
PrWD  in  32  CPU write data
PrRD  out  32  registered read data, valid when PrReady=1
PrReady  out  1  one-cycle completion pulse
PrErr  out  1  access fault, valid with PrReady
DEV_Addr  out  32  byte offset within the selected slot (PrAddr minus slot base)
DEV_WD  out  32  PrWD passthrough
DEV_WE  out  DEV_NUM  one-hot device write enable
DEV_RD  in  32*DEV_NUM  device read data, slot i at bits [32*i+31:32*i]
DEV_IRQ  in  DEV_NUM  device interrupt levels
HWInt  out  6  masked pending interrupts to CP0; bits >= DEV_NUM tie to 0

Behaviour:
- Decode:
  - hit_i = PrAddr inside slot i range and PrAddr[1:0]==0.
  - Control hits are CTRL_BASE+0 (PEND), +4 (MASK), +8 (ERRADDR), each word-aligned.
  - Anything else is a fault.
- Request cycle = PrWE|PrRE. If both are high, the access is a write and the read is ignored; one response only.
- Write to slot i: DEV_WE[i]=1 combinationally in the request cycle only. DEV_WE=0 when there is no request, no hit, or the access is a read.
- Write to a control register takes effect at the next edge:
  - PEND is write-1-to-clear.
  - MASK[DEV_NUM-1:0] is read/write.
  - ERRADDR is read-only; a write is ignored and is not a fault.
- Read: the selected DEV_RD slice or control register is sampled at the request-cycle edge into the PrRD register. A fault yields 0.
- Response: PrReady=1 exactly one cycle after every request (read or write).
  - PrErr=1 with PrReady when the request was a fault.
  - PrRD holds its value until the next read response; writes and faults do not update it, except that a faulting read loads 0.
- Faults: no DEV_WE asserted; ERRADDR<=PrAddr at the request edge; repeated faults overwrite ERRADDR.
- Back-to-back requests on consecutive cycles are legal: one PrReady per cycle, in order.
- Interrupts:
  - irq_q registers DEV_IRQ every cycle.
  - PEND[i] sets on the rising edge (DEV_IRQ[i] & ~irq_q[i]).
  - A same-cycle set and W1C clear resolves to set.
  - PEND stays latched while DEV_IRQ stays high after a clear; it is not re-armed until the next rising edge.
  - HWInt[i] = PEND[i] & MASK[i], driven from registers (no combinational path from DEV_IRQ).
- Reset (reset==0 at a clk edge):
  - PrRD=0, PrReady=0, PrErr=0, PEND=0, irq_q=0, ERRADDR=0, MASK=all ones.
  - Reset mid-access drops the pending response; no PrReady is generated for a request issued in the reset cycle.
- Address arithmetic: DEV_Addr is 32-bit unsigned subtraction. It is meaningful only when a slot hits; otherwise it is 0.

Test Plan:
- Reset, then read 0x7F44 -> next cycle PrReady=1, PrErr=0, PrRD=32'h3; HWInt=0.
- Write 0x7F14 data 0xABCD -> same cycle DEV_WE=2'b10, DEV_Addr=4, DEV_WD=0xABCD; next cycle PrReady=1, PrErr=0.
- Read 0x7F08 with DEV_RD slot0=0x1234 -> next cycle PrRD=0x1234, PrReady=1. Back-to-back read of 0x7F10 (slot1=0x55) the following cycle -> PrRD=0x55 one cycle later.
- Faults:
  - Read 0x7F0C (gap) -> PrErr=1, PrRD=0, ERRADDR=0x7F0C.
  - Write 0x7F02 (misaligned) -> DEV_WE=0, PrErr=1, ERRADDR=0x7F02.
- DEV_IRQ[1] rises and stays high -> PEND=2'b10, HWInt=6'b000010.
  - Write MASK=1 -> HWInt=0.
  - Write PEND=2 -> PEND=0 and stays 0 while the line is held high.
  - Drop then re-raise the line in the same cycle as a W1C -> PEND[1]=1.
- Assert reset low mid-transaction (read issued the previous cycle) -> PrReady=0 after the edge; MASK returns to 2'b11.

Source files
------------

// File: rtl/sys_bridge_if.sv
`default_nettype none
// ============================================================================
// sys_bridge_if : CPU-side and device-side bus bundle of the system bridge
// Revision      : 1.0
// ============================================================================
interface sys_bridge_if #(
  parameter int DEV_NUM = 2
);
  logic [31:0]           PrAddr;
  logic                  PrWE;
  logic                  PrRE;
  logic [31:0]           PrWD;
  logic [31:0]           PrRD;
  logic                  PrReady;
  logic                  PrErr;
  logic [31:0]           DEV_Addr;
  logic [31:0]           DEV_WD;
  logic [DEV_NUM-1:0]    DEV_WE;
  logic [32*DEV_NUM-1:0] DEV_RD;
  logic [DEV_NUM-1:0]    DEV_IRQ;
  logic [5:0]            HWInt;

  // Bridge view
  modport slave (
    input  PrAddr, PrWE, PrRE, PrWD, DEV_RD, DEV_IRQ,
    output PrRD, PrReady, PrErr, DEV_Addr, DEV_WD, DEV_WE, HWInt
  );

  // CPU / device environment view
  modport master (
    output PrAddr, PrWE, PrRE, PrWD, DEV_RD, DEV_IRQ,
    input  PrRD, PrReady, PrErr, DEV_Addr, DEV_WD, DEV_WE, HWInt
  );
endinterface
`default_nettype wire

// File: rtl/sys_bridge.sv
`default_nettype none
// ============================================================================
// sys_bridge : CPU-to-peripheral bridge with slot decode and sticky IRQ pending
// Revision   : 1.0
// ============================================================================
module sys_bridge #(
  parameter int          DEV_NUM    = 2,
  parameter logic [31:0] DEV_BASE   = 32'h0000_7F00,
  parameter logic [31:0] DEV_STRIDE = 32'h10,
  parameter int          DEV_WORDS  = 3,
  parameter logic [31:0] CTRL_BASE  = 32'h0000_7F40
) (
  input  logic         clk,
  input  logic         reset,
  sys_bridge_if.slave  bus
);
  localparam logic [31:0] SLOT_BYTES = 32'(4 * DEV_WORDS);

  logic [DEV_NUM-1:0] r_irq_q;
  logic [DEV_NUM-1:0] r_pend;
  logic [DEV_NUM-1:0] r_mask;
  logic [31:0]        r_err_addr;
  logic [31:0]        r_rd;
  logic               r_ready;
  logic               r_err;

  logic               w_req;
  logic               w_wr;
  logic               w_rd;
  logic               w_aligned;
  logic               w_hit_pend;
  logic               w_hit_mask;
  logic               w_hit_eaddr;
  logic               w_fault;
  logic [DEV_NUM-1:0] w_slot_hit;
  logic [31:0]        w_slot_off [DEV_NUM];
  logic [31:0]        w_dev_addr;
  logic [31:0]        w_rdata;
  logic [DEV_NUM-1:0] w_pend_clr;
  logic [DEV_NUM-1:0] w_irq_rise;
  logic [5:0]         w_hwint;

  assign w_req     = bus.PrWE | bus.PrRE;
  assign w_wr      = bus.PrWE;
  assign w_rd      = bus.PrRE & ~bus.PrWE;
  assign w_aligned = (bus.PrAddr[1:0] == 2'b00);

  // Unsigned wrap makes addresses below a slot base land far outside its range
  for (genvar i = 0; i < DEV_NUM; i++) begin : g_slot
    localparam logic [31:0] SLOT_BASE = DEV_BASE + DEV_STRIDE * 32'(i);
    assign w_slot_off[i] = bus.PrAddr - SLOT_BASE;
    assign w_slot_hit[i] = (w_slot_off[i] < SLOT_BYTES) && w_aligned;
  end

  assign w_hit_pend  = (bus.PrAddr == CTRL_BASE) && w_aligned;
  assign w_hit_mask  = (bus.PrAddr == CTRL_BASE + 32'd4) && w_aligned;
  assign w_hit_eaddr = (bus.PrAddr == CTRL_BASE + 32'd8) && w_aligned;
  assign w_fault     = ~(|w_slot_hit | w_hit_pend | w_hit_mask | w_hit_eaddr);

  always_comb begin
    w_dev_addr = '0;
    w_rdata    = '0;
    for (int i = 0; i < DEV_NUM; i++) begin
      if (w_slot_hit[i]) begin
        w_dev_addr = w_slot_off[i];
        w_rdata    = bus.DEV_RD[32*i +: 32];
      end
    end
    if (w_hit_pend)  w_rdata = 32'(r_pend);
    if (w_hit_mask)  w_rdata = 32'(r_mask);
    if (w_hit_eaddr) w_rdata = r_err_addr;
  end

  assign w_pend_clr = (w_wr && w_hit_pend) ? bus.PrWD[DEV_NUM-1:0] : '0;
  assign w_irq_rise = bus.DEV_IRQ & ~r_irq_q;

  always_comb begin
    w_hwint              = '0;
    w_hwint[DEV_NUM-1:0] = r_pend & r_mask;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq_q    <= '0;
      r_pend     <= '0;
      r_mask     <= '1;
      r_err_addr <= '0;
      r_rd       <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_irq_q <= bus.DEV_IRQ;
      r_ready <= w_req;
      r_err   <= w_req & w_fault;
      // Set term applied last so a coincident rising edge beats the W1C
      r_pend  <= (r_pend & ~w_pend_clr) | w_irq_rise;
      if (w_wr && w_hit_mask) r_mask <= bus.PrWD[DEV_NUM-1:0];
      if (w_req && w_fault)   r_err_addr <= bus.PrAddr;
      if (w_rd)               r_rd <= w_rdata;
    end
  end

  assign bus.DEV_WE   = w_wr ? w_slot_hit : '0;
  assign bus.DEV_Addr = w_dev_addr;
  assign bus.DEV_WD   = bus.PrWD;
  assign bus.PrRD     = r_rd;
  assign bus.PrReady  = r_ready;
  assign bus.PrErr    = r_err;
  assign bus.HWInt    = w_hwint;

endmodule
`default_nettype wire

// File: tb/tb_sys_bridge.sv
`default_nettype none
// ============================================================================
// tb_sys_bridge : vector table plus hand sequences, scoreboard on responses
// Revision      : 1.0
// ============================================================================
module tb_sys_bridge;
  logic clk;
  logic reset;

  sys_bridge_if #(.DEV_NUM(2)) bus ();

  sys_bridge #(.DEV_NUM(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        re;
    logic [31:0] wd;
    logic [63:0] devrd;
    logic [1:0]  exp_we;
    logic [31:0] exp_daddr;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } resp_t;

  vec_t        vecs [15];
  resp_t       sb [$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one request at the falling edge, check same-cycle outputs, queue the response
  task automatic issue(input string name, input logic [31:0] addr, input logic we,
                       input logic re, input logic [31:0] wd, input logic [63:0] devrd,
                       input logic [1:0] irq, input logic [1:0] exp_we,
                       input logic [31:0] exp_daddr, input logic exp_err,
                       input logic [31:0] exp_rd);
    resp_t r;
    @(negedge clk);
    bus.PrAddr  = addr;
    bus.PrWE    = we;
    bus.PrRE    = re;
    bus.PrWD    = wd;
    bus.DEV_RD  = devrd;
    bus.DEV_IRQ = irq;
    #1;
    chk({name, "/dev_we"}, 32'(bus.DEV_WE), 32'(exp_we));
    chk({name, "/dev_addr"}, bus.DEV_Addr, exp_daddr);
    if (we) chk({name, "/dev_wd"}, bus.DEV_WD, wd);
    if (!we) model_rd = exp_rd;
    r.err = exp_err;
    r.rd  = model_rd;
    sb.push_back(r);
  endtask

  task automatic idle(input logic [1:0] irq);
    @(negedge clk);
    bus.PrWE    = 1'b0;
    bus.PrRE    = 1'b0;
    bus.DEV_IRQ = irq;
  endtask

  // Response monitor: each queued request must complete exactly one cycle later
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp/ready", 32'(bus.PrReady), 32'd1);
        chk("resp/err", 32'(bus.PrErr), 32'(e.err));
        chk("resp/rd", bus.PrRD, e.rd);
      end else begin
        chk("resp/no_ready", 32'(bus.PrReady), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h7F44, 1'b0, 1'b1, 32'h0,    64'h0, 2'b00, 32'h0, 1'b0, 32'h3};
    vecs[1]  = '{32'h7F14, 1'b1, 1'b0, 32'hABCD, 64'h0, 2'b10, 32'h4, 1'b0, 32'h0};
    vecs[2]  = '{32'h7F08, 1'b0, 1'b1, 32'h0, {32'h55, 32'h1234}, 2'b00, 32'h8, 1'b0, 32'h1234};
    vecs[3]  = '{32'h7F10, 1'b0, 1'b1, 32'h0, {32'h55, 32'h1234}, 2'b00, 32'h0, 1'b0, 32'h55};
    vecs[4]  = '{32'h7F0C, 1'b0, 1'b1, 32'h0,    64'h0, 2'b00, 32'h0, 1'b1, 32'h0};
    vecs[5]  = '{32'h7F48, 1'b0, 1'b1, 32'h0,    64'h0, 2'b00, 32'h0, 1'b0, 32'h7F0C};
    vecs[6]  = '{32'h7F02, 1'b1, 1'b0, 32'h1,    64'h0, 2'b00, 32'h0, 1'b1, 32'h0};
    vecs[7]  = '{32'h7F48, 1'b0, 1'b1, 32'h0,    64'h0, 2'b00, 32'h0, 1'b0, 32'h7F02};
    vecs[8]  = '{32'h7F48, 1'b1, 1'b0, 32'hFFFF, 64'h0, 2'b00, 32'h0, 1'b0, 32'h0};
    vecs[9]  = '{32'h7F48, 1'b0, 1'b1, 32'h0,    64'h0, 2'b00, 32'h0, 1'b0, 32'h7F02};
    vecs[10] = '{32'h7F00, 1'b1, 1'b1, 32'h7,    64'h0, 2'b01, 32'h0, 1'b0, 32'h0};
    vecs[11] = '{32'h7F18, 1'b0, 1'b1, 32'h0, {32'hCAFE, 32'h1}, 2'b00, 32'h8, 1'b0, 32'hCAFE};
    vecs[12] = '{32'h7F1C, 1'b0, 1'b1, 32'h0,    64'h0, 2'b00, 32'h0, 1'b1, 32'h0};
    vecs[13] = '{32'h7F4C, 1'b1, 1'b0, 32'h5,    64'h0, 2'b00, 32'h0, 1'b1, 32'h0};
    vecs[14] = '{32'h6F00, 1'b0, 1'b1, 32'h0,    64'h0, 2'b00, 32'h0, 1'b1, 32'h0};

    reset       = 1'b0;
    bus.PrAddr  = '0;
    bus.PrWE    = 1'b0;
    bus.PrRE    = 1'b0;
    bus.PrWD    = '0;
    bus.DEV_RD  = '0;
    bus.DEV_IRQ = '0;
    model_rd    = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset/ready", 32'(bus.PrReady), 32'd0);
    chk("reset/err", 32'(bus.PrErr), 32'd0);
    chk("reset/rd", bus.PrRD, 32'd0);
    chk("reset/hwint", 32'(bus.HWInt), 32'd0);
    reset = 1'b1;

    issue("eaddr_reset", 32'h7F48, 1'b0, 1'b1, 32'h0, 64'h0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0);

    // Consecutive back-to-back requests from the table
    for (int i = 0; i < 15; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].re, vecs[i].wd,
            vecs[i].devrd, 2'b00, vecs[i].exp_we, vecs[i].exp_daddr, vecs[i].exp_err,
            vecs[i].exp_rd);
    end
    idle(2'b00);
    idle(2'b00);

    // Interrupt rise, masking, W1C while held high
    idle(2'b10);
    issue("irq_pend", 32'h7F40, 1'b0, 1'b1, 32'h0, 64'h0, 2'b10, 2'b00, 32'h0, 1'b0, 32'h2);
    chk("irq/hwint_set", 32'(bus.HWInt), 32'h2);
    issue("mask_wr1", 32'h7F44, 1'b1, 1'b0, 32'h1, 64'h0, 2'b10, 2'b00, 32'h0, 1'b0, 32'h0);
    issue("irq_pend_masked", 32'h7F40, 1'b0, 1'b1, 32'h0, 64'h0, 2'b10, 2'b00, 32'h0, 1'b0, 32'h2);
    chk("irq/hwint_masked", 32'(bus.HWInt), 32'h0);
    issue("mask_wr3", 32'h7F44, 1'b1, 1'b0, 32'h3, 64'h0, 2'b10, 2'b00, 32'h0, 1'b0, 32'h0);
    issue("pend_w1c", 32'h7F40, 1'b1, 1'b0, 32'h2, 64'h0, 2'b10, 2'b00, 32'h0, 1'b0, 32'h0);
    issue("pend_cleared", 32'h7F40, 1'b0, 1'b1, 32'h0, 64'h0, 2'b10, 2'b00, 32'h0, 1'b0, 32'h0);
    idle(2'b10);
    idle(2'b10);
    idle(2'b10);
    issue("pend_held", 32'h7F40, 1'b0, 1'b1, 32'h0, 64'h0, 2'b10, 2'b00, 32'h0, 1'b0, 32'h0);
    chk("irq/hwint_held", 32'(bus.HWInt), 32'h0);

    // Re-raise coinciding with a W1C: the set wins
    idle(2'b00);
    idle(2'b00);
    issue("w1c_vs_rise", 32'h7F40, 1'b1, 1'b0, 32'h2, 64'h0, 2'b10, 2'b00, 32'h0, 1'b0, 32'h0);
    issue("pend_rearmed", 32'h7F40, 1'b0, 1'b1, 32'h0, 64'h0, 2'b10, 2'b00, 32'h0, 1'b0, 32'h2);
    chk("irq/hwint_rearmed", 32'(bus.HWInt), 32'h2);

    // Reset arriving with a request in flight
    issue("mask_wr1b", 32'h7F44, 1'b1, 1'b0, 32'h1, 64'h0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0);
    issue("mask_rd1", 32'h7F44, 1'b0, 1'b1, 32'h0, 64'h0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h1);
    @(negedge clk);
    reset      = 1'b0;
    bus.PrAddr = 32'h7F44;
    bus.PrRE   = 1'b1;
    bus.PrWE   = 1'b0;
    @(negedge clk);
    #1;
    chk("midreset/ready", 32'(bus.PrReady), 32'd0);
    chk("midreset/err", 32'(bus.PrErr), 32'd0);
    chk("midreset/rd", bus.PrRD, 32'd0);
    chk("midreset/hwint", 32'(bus.HWInt), 32'd0);
    reset    = 1'b1;
    bus.PrRE = 1'b0;
    model_rd = '0;
    idle(2'b00);
    issue("mask_after_reset", 32'h7F44, 1'b0, 1'b1, 32'h0, 64'h0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h3);
    idle(2'b00);
    idle(2'b00);
    idle(2'b00);
    chk("sb/drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
